dm_lsu: RTL
===========

Name: dm_lsu

Overview:
- Load/store unit that sits directly upstream of the 64Kx32 data memory (DM) and is the only block that drives the DM control, address and write-data pins.
- Accepts byte-addressed, size-qualified load/store requests from the MEM pipeline stage over a valid/ready handshake.
- Converts them to DM word accesses. Sub-word stores are done as read-modify-write; loaded sub-words are sign- or zero-extended.
- Returns one response per request, carrying read data or an error flag.

Parameters:
- ADDR_W, 32: request byte-address width.
- ADSize, 16: DM word-address width (DM depth = 2^ADSize words).
- DASize, 32: data width; fixed at 32 (4 byte lanes).

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_write, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_signed, input, 1: load sign-extend when 1; ignored for stores.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, DASize: store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid, output, 1: response present.
- resp_ready, input, 1: consumer takes response.
- resp_rdata, output, DASize: load result after extension; 0 for stores and errors.
- resp_err, output, 1: request was misaligned, out of range or had an illegal size.
- DM_enable, output, 1: DM access strobe.
- DM_write, output, 1: 1 = DM write, 0 = DM read.
- DM_address, output, ADSize: DM word address = addr_q[ADSize+1:2].
- DM_in, output, DASize: DM write data.
- DM_out, input, DASize: DM read data, registered by DM on the edge that ends a read cycle.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- While rst = 0:
  - State is IDLE and all registers are 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - req_ready = 0.
  - DM_enable, DM_write, DM_address and DM_in are all forced to 0, so a store in flight is dropped and no partial write reaches DM.
- req_ready = 1 only in state IDLE with rst = 1. A handshake is req_valid && req_ready at posedge. On handshake, latch write, size, signed, addr and wdata into *_q registers.
- Error check at handshake, giving err = 1 when any of these hold:
  - size == 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr[ADDR_W-1:ADSize+2] != 0.
  - An error goes IDLE -> RESP with resp_err = 1 and performs no DM access.
- States and transitions:
  - IDLE: on a non-error load -> LD_RD; on a word store -> ST_WR; on a byte/half store -> ST_RD.
  - LD_RD: DM_enable = 1, DM_write = 0. Next state LD_CAP.
  - LD_CAP: select the lane from DM_out, extend it, register it into resp_rdata. Next state RESP.
  - ST_RD: DM_enable = 1, DM_write = 0. Next state ST_MERGE.
  - ST_MERGE: merge_q = DM_out with the target lane(s) replaced by wdata_q. Next state ST_WR.
  - ST_WR: DM_enable = 1, DM_write = 1, DM_in = merge_q for sub-word stores or wdata_q for word stores. Next state RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are held stable. On resp_ready -> IDLE. resp_valid holds while resp_ready = 0.
- DM pins in every state other than LD_RD, ST_RD and ST_WR: DM_enable = 0 and DM_write = 0. DM_address is still driven from addr_q.
- Lanes are little-endian: byte k = bits [8k+7:8k], selected by addr[1:0]; half h = bits [16h+15:16h], selected by addr[1].
- Extension: signed copies the MSB of the byte/half into the upper bits; unsigned zero-fills. Word loads are passed through unchanged.
- Latency, in cycles from the handshake edge to the first cycle with resp_valid = 1:
  - load: 3;
  - word store: 2;
  - byte/half store: 4;
  - error: 1.
- Throughput: one outstanding request. The next request can be accepted the cycle after the resp_valid && resp_ready edge.
- Address 0x3FFFC (the last DM word) is legal; 0x40000 sets resp_err.

Test Plan:
- Word store, then word load, both at 0x100 with data 0xDEADBEEF -> DM word 0x40 = 0xDEADBEEF; load response 0xDEADBEEF, err 0, arriving 3 cycles after accept.
- Preload 0x11223344 at 0x200, then byte store of 0xAA at 0x202 -> DM read then write; DM word 0x80 = 0x11AA3344; store response 4 cycles after accept.
- Signed half load at 0x202 of 0x8001_7FFF gives 0xFFFF8001; unsigned gives 0x00008001; signed byte load at 0x200 gives 0xFFFFFFFF for byte 0xFF.
- Half load at 0x3, word load at 0x2 and byte load at 0x40000 each give resp_err = 1 and rdata = 0 after 1 cycle, with DM_enable = 0 throughout.
- Hold resp_ready = 0 for 5 cycles after resp_valid -> resp_valid and rdata stay stable and req_ready stays 0; accept on the next request after release.
- Assert rst = 0 during ST_MERGE of a byte store -> DM_write is never 1, the DM word is unchanged, and after release the block is in IDLE with req_ready = 1.

Source files
------------

// File: rtl/dm_lsu.sv
// Load/store unit in front of the 64Kx32 data memory; the only driver of DM pins.
// Latency handshake->resp_valid: load 3, word store 2, sub-word store 4, error 1.
// Backpressure: one request in flight; req_ready low until the response is taken.
module dm_lsu #(
    parameter int ADDR_W = 32,
    parameter int ADSize = 16,
    parameter int DASize = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DASize-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DASize-1:0] resp_rdata,
    output logic              resp_err,
    output logic              DM_enable,
    output logic              DM_write,
    output logic [ADSize-1:0] DM_address,
    output logic [DASize-1:0] DM_in,
    input  logic [DASize-1:0] DM_out
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_RD    = 3'd1;
    localparam logic [2:0] LD_CAP   = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;
    localparam logic [2:0] ST_MERGE = 3'd4;
    localparam logic [2:0] ST_WR    = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]        state;
    logic              write_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADSize+1:0] addr_q;
    logic [DASize-1:0] wdata_q;
    logic [DASize-1:0] merge_q;
    logic [DASize-1:0] rdata_q;
    logic              err_q;

    logic              hs;
    logic              req_err;
    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DASize-1:0] load_ext;
    logic [DASize-1:0] merge_nxt;

    assign req_ready = rst && (state == IDLE);
    assign hs        = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ((req_addr >> (ADSize + 2)) != '0)
            req_err = 1'b1;
    end

    assign byte_sh   = {addr_q[1:0], 3'b000};
    assign half_sh   = {addr_q[1], 4'b0000};
    assign byte_lane = DM_out[byte_sh +: 8];
    assign half_lane = DM_out[half_sh +: 16];

    always_comb begin
        load_ext = DM_out;
        case (size_q)
            SZ_BYTE: load_ext = {{(DASize-8){signed_q & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = {{(DASize-16){signed_q & half_lane[15]}}, half_lane};
            default: load_ext = DM_out;
        endcase
    end

    // Read-modify-write: only the addressed lane(s) of the fetched word change.
    always_comb begin
        merge_nxt = DM_out;
        if (size_q == SZ_BYTE)
            merge_nxt[byte_sh +: 8] = wdata_q[7:0];
        else
            merge_nxt[half_sh +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        addr_q   <= req_addr[ADSize+1:0];
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                        if (req_err)
                            state <= RESP;
                        else if (!req_write)
                            state <= LD_RD;
                        else if (req_size == SZ_WORD)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                LD_RD:    state <= LD_CAP;
                LD_CAP: begin
                    rdata_q <= load_ext;
                    state   <= RESP;
                end
                ST_RD:    state <= ST_MERGE;
                ST_MERGE: begin
                    merge_q <= merge_nxt;
                    state   <= ST_WR;
                end
                ST_WR:    state <= RESP;
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default:  state <= IDLE;
            endcase
        end
    end

    // DM pins are gated by rst so an interrupted store can never reach the array.
    assign DM_enable  = rst && (state == LD_RD || state == ST_RD || state == ST_WR);
    assign DM_write   = rst && (state == ST_WR) && write_q;
    assign DM_address = rst ? addr_q[ADSize+1:2] : '0;
    assign DM_in      = (rst && state == ST_WR) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : '0;

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
